isqrt_seq: RTL and testbench

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_pkg.sv | 10 +
 rtl/isqrt_seq_if.sv | 14 +
 rtl/isqrt_step.sv | 20 ++
 rtl/isqrt_seq.sv | 74 +++++++
 tb/tb_isqrt_seq.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared state type and widths for the sequential integer square root
package isqrt_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int SUM_W = 16;
  localparam int ROOT_W = 8;
  localparam int REM_W = 9;
  localparam int ITER_CNT = 8;
  localparam int ACC_W = REM_W + 1;
  localparam int CNT_W = $clog2(ITER_CNT);
endpackage

// File: rtl/isqrt_seq_if.sv
// isqrt_seq_if: radicand-in / root-out handshake bundle for isqrt_seq
interface isqrt_seq_if;
  import isqrt_pkg::*;
  logic [SUM_W-1:0]  in_sum;
  logic              in_valid;
  logic              in_ready;
  logic [ROOT_W-1:0] out_root;
  logic [REM_W-1:0]  out_rem;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  modport master (output in_sum, in_valid, out_ready, input in_ready, out_root, out_rem, out_valid, busy);
  modport slave (input in_sum, in_valid, out_ready, output in_ready, out_root, out_rem, out_valid, busy);
endinterface

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring radix-4 digit of the square root, yielding one root bit
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [ACC_W-1:0]  rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        pair,
  output logic [ACC_W-1:0]  new_rem,
  output logic              new_bit
);
  logic [ACC_W+1:0] shifted;
  logic [ACC_W+1:0] trial;
  // partial remainder never exceeds 2*root, so the 10-bit result always fits
  always_comb begin
    shifted = {rem, pair};
    trial = {2'b00, root, 2'b01};
    new_bit = shifted >= trial;
    new_rem = ACC_W'(new_bit ? shifted - trial : shifted);
  end
endmodule

// File: rtl/isqrt_seq.sv
// isqrt_seq: 8-cycle sequential 16-bit integer square root with remainder
// Optional ISQRT_ROUND_EN rounds the root to nearest (saturating at 255).
module isqrt_seq
  import isqrt_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  input logic        ena,
  isqrt_seq_if.slave bus
);
  state_t            state, state_nxt;
  logic [SUM_W-1:0]  sum;
  logic [ACC_W-1:0]  rem_acc, new_rem;
  logic [ROOT_W-1:0] root_acc, root_nxt, root_fin;
  logic [CNT_W-1:0]  cnt;
  logic              new_bit, accept, last;
  isqrt_step u_step (
    .rem     (rem_acc),
    .root    (root_acc),
    .pair    (sum[SUM_W-1 -: 2]),
    .new_rem (new_rem),
    .new_bit (new_bit)
  );
  assign root_nxt = {root_acc[ROOT_W-2:0], new_bit};
`ifdef ISQRT_ROUND_EN
  assign root_fin = (new_rem > {2'b00, root_nxt} && root_nxt != '1) ? root_nxt + 1'b1 : root_nxt;
`else
  assign root_fin = root_nxt;
`endif
  assign bus.in_ready = state == IDLE && ena;
  assign bus.busy = state != IDLE;
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt == CNT_W'(ITER_CNT - 1);
  always_comb begin
    state_nxt = state;
    if (ena)
      state_nxt = state == IDLE ? (bus.in_valid ? CALC : IDLE) :
                  state == CALC ? (last ? DONE : CALC) :
                  (bus.out_valid && bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      rem_acc <= '0;
      root_acc <= '0;
      cnt <= '0;
      bus.out_root <= '0;
      bus.out_rem <= '0;
      bus.out_valid <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        sum <= bus.in_sum;
        rem_acc <= '0;
        root_acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        sum <= {sum[SUM_W-3:0], 2'b00};
        rem_acc <= new_rem;
        root_acc <= root_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          bus.out_root <= root_fin;
          bus.out_rem <= new_rem[REM_W-1:0];
          bus.out_valid <= 1'b1;
        end
      end else if (state == DONE && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed table, handshake corner cases and random vectors for isqrt_seq
module tb_isqrt_seq;
  import isqrt_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  isqrt_seq_if bus();
  isqrt_seq dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] sum;
    int          root;
    int          rem;
    int          rroot;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int floor_root(int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  function automatic int ref_root(int x);
    int r = floor_root(x);
`ifdef ISQRT_ROUND_EN
    if (x - r * r > r && r < 255) r++;
`endif
    return r;
  endfunction
  // enters and leaves on a falling edge; stall drops ena for stall_len edges after edge stall_at
  task automatic xact(input logic [15:0] x, input int er, input int em, input int stall_at, input int stall_len);
    int lat = 0;
    int k = 0;
    bus.in_sum = x;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sum = ~x;
    while (!bus.out_valid && lat < 40) begin
      if (lat == stall_at) ena = 1'b0;
      if (lat == stall_at + stall_len) ena = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ena = 1'b1;
    chk("latency", lat, 8 + stall_len);
    chk("root", int'(bus.out_root), er);
    chk("rem", int'(bus.out_rem), em);
    @(posedge clk);
    @(negedge clk);
    chk("valid_clr", int'(bus.out_valid), 0);
    chk("ready_back", int'(bus.in_ready), 1);
  endtask
  initial begin
    int bad;
    bus.in_sum = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tbl[0]  = '{16'd25, 5, 0, 5};
    tbl[1]  = '{16'd0, 0, 0, 0};
    tbl[2]  = '{16'd65535, 255, 510, 255};
    tbl[3]  = '{16'd24, 4, 8, 5};
    tbl[4]  = '{16'd20, 4, 4, 4};
    tbl[5]  = '{16'd1, 1, 0, 1};
    tbl[6]  = '{16'd2, 1, 1, 1};
    tbl[7]  = '{16'd3, 1, 2, 2};
    tbl[8]  = '{16'd65025, 255, 0, 255};
    tbl[9]  = '{16'd65024, 254, 508, 255};
    tbl[10] = '{16'd256, 16, 0, 16};
    tbl[11] = '{16'd272, 16, 16, 16};
    tbl[12] = '{16'd273, 16, 17, 17};
    #12;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_root", int'(bus.out_root), 0);
    chk("rst_rem", int'(bus.out_rem), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++)
`ifdef ISQRT_ROUND_EN
      xact(tbl[i].sum, tbl[i].rroot, tbl[i].rem, -1, 0);
`else
      xact(tbl[i].sum, tbl[i].root, tbl[i].rem, -1, 0);
`endif
    xact(16'd1000, ref_root(1000), 1000 - floor_root(1000) ** 2, 2, 5);
    // result held under backpressure while a second radicand waits
    bus.in_sum = 16'd100;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_sum = 16'd200;
    for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_root !== 8'd10 || bus.out_rem !== 9'd0 || !bus.out_valid || bus.in_ready) bad++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_busy", int'(bus.busy), 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release", int'(bus.in_ready), 1);
    xact(16'd200, ref_root(200), 200 - floor_root(200) ** 2, -1, 0);
    // reset mid-calculation discards the operation
    bus.in_sum = 16'd50000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_root", int'(bus.out_root), 0);
    chk("mid_rst_rem", int'(bus.out_rem), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) bad++;
    end
    chk("no_emit", bad, 0);
    for (int i = 0; i < 300; i++) begin
      int x = int'($urandom_range(0, 65535));
      int sa = (i % 3 == 0) ? int'($urandom_range(0, 6)) : -1;
      int sl = (sa >= 0) ? int'($urandom_range(1, 3)) : 0;
      xact(16'(x), ref_root(x), x - floor_root(x) * floor_root(x), sa, sl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
